scan_tester: RTL and testbench
==============================

Name: scan_tester

Overview:
- On-chip scan test controller: the driving end of a mux-scan chain (scan-enable M, scan-in I, scan-out O).
- Per test vector it performs three steps:
  - shifts a stimulus pattern into the chain;
  - applies one functional capture cycle with primary-input values;
  - shifts the captured response out and compares it against an expected pattern under a mask.
- Sits between a vector source (host, ROM or bench) and the scan ports of a device under test (DUT) clocked by the same clock.

Parameters:
- CHAIN_LEN, 3: number of scan flops in the chain (minimum 1).
- PI_W, 3: number of primary inputs driven during capture.
- CW, derived $clog2(CHAIN_LEN+1): width of the shift counter.

Ports:
- clk  in  1  system clock; all flops rising-edge.
- n_reset  in  1  reset; asynchronous, active-low.
- start  in  1  vector request; accepted when ready=1.
- ready  out  1  high in IDLE only.
- vec_in  in  CHAIN_LEN  stimulus; bit k loads chain flop k (flop 0 is nearest scan-in).
- pi_in  in  PI_W  primary-input values applied in the capture cycle.
- exp_in  in  CHAIN_LEN  expected response, same bit mapping as vec_in.
- mask_in  in  CHAIN_LEN  1 = compare this bit, 0 = don't care.
- scan_m  out  1  DUT scan-enable (1 = shift, 0 = functional).
- scan_i  out  1  DUT scan-in.
- scan_o  in  1  DUT scan-out (Q of flop CHAIN_LEN-1).
- pi_out  out  PI_W  DUT primary inputs.
- resp  out  CHAIN_LEN  captured response, valid while done=1 and held until the next accept.
- done  out  1  one-cycle pulse when a vector completes.
- pass  out  1  compare result; valid with done, held with resp.

Behaviour:
- All outputs are registered. Reset values: ready=1, scan_m=0, scan_i=0, pi_out=0, resp=0, done=0, pass=0, state=IDLE, counter=0.
- Accept: start=1 in IDLE registers vec_in, pi_in, exp_in and mask_in. Inputs are don't-care afterwards. start outside IDLE is ignored.
- IDLE:
  - scan_m=0, ready=1.
  - On accept, go to SHIFT_IN with cnt=0.
- SHIFT_IN (CHAIN_LEN cycles):
  - scan_m=1, scan_i=vec[CHAIN_LEN-1-cnt], so the MSB is shifted first.
  - After the last shift edge, DUT flop k holds vec[k].
  - When cnt=CHAIN_LEN-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - scan_m=0, pi_out=pi. The DUT flops load their functional D on this edge.
  - Then go to SHIFT_OUT with cnt=0.
- SHIFT_OUT (CHAIN_LEN cycles):
  - scan_m=1, scan_i=0 (flush fill).
  - At each rising edge the tester samples scan_o before the DUT shifts. Sample j is written to resp_sr[CHAIN_LEN-1-j], so the first sample is flop CHAIN_LEN-1.
  - When cnt=CHAIN_LEN-1, go to DONE.
- DONE (1 cycle):
  - done=1, resp=resp_sr, pass=((resp_sr ^ exp) & mask)==0, scan_m=0.
  - Then go to IDLE.
- pi_out holds its last capture value outside CAPTURE, to avoid spurious functional glitches.
- Latency: accept edge to done high is 2*CHAIN_LEN+2 cycles. Back-to-back vectors are possible because ready returns the cycle after DONE.
- Boundary cases:
  - mask=0 gives pass=1 regardless of the response.
  - CHAIN_LEN=1 degenerates correctly to one shift-in cycle and one shift-out cycle.
  - Counter wraps to 0 on every state exit.
- Reset mid-operation: asserting n_reset in any state immediately forces the reset values (scan_m=0 asynchronously). The partial vector is discarded with no done pulse.

Decomposition:
- Package scan_pkg:
  - state enum st_t {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE};
  - default CHAIN_LEN and PI_W constants.
- One natural sub-module: scan_shreg, a CHAIN_LEN-bit parallel-load serial-out / serial-in parallel-out register. It is used twice: once for stimulus serialisation and once for response capture.
- FSM and counter stay in scan_tester.

Test Plan:
The bench uses a behavioural 3-flop mux-scan chain model whose functional D is flop k <= state[k] ^ pi[k].
- Reset: hold n_reset low mid-SHIFT_IN, release. Required: scan_m=0 immediately, ready=1, no done, next vector runs cleanly.
- Basic: vec=3'b101, pi=3'b000, exp=3'b101, mask=3'b111. Required: chain holds 101 before capture, resp=101, pass=1, done exactly 8 cycles after accept.
- Capture: vec=3'b110, pi=3'b011, exp=3'b101, mask=3'b111. Required: resp=101, pass=1. Repeat with exp=3'b100: pass=0.
- Mask: vec=3'b000, pi=3'b111, exp=3'b000, mask=3'b000. Required: resp=111, pass=1. Repeat with mask=3'b010: pass=0.
- Handshake and back-to-back:
  - start held high continuously: vectors complete every 9 cycles and start is ignored outside IDLE.
  - vec_in changed after accept: the change has no effect on the current vector.
- Flush: after any vector, the chain contents observed in the model are 000 (scan_i=0 during SHIFT_OUT).

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default sizing for the scan test controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } st_t;

  localparam int unsigned DEF_CHAIN_LEN = 3;
  localparam int unsigned DEF_PI_W      = 3;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load / serial-shift register, MSB is the serial output, serial input enters at bit 0.
module scan_shreg #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q,
  output logic         o_sout
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_shifted;

  // A one-bit register simply takes the serial input on a shift.
  generate
    if (W == 1) begin : g_one
      assign w_shifted = i_sin;
    end else begin : g_multi
      assign w_shifted = {r_q[W-2:0], i_sin};
    end
  endgenerate

  // Load has priority over shift.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= w_shifted;
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_q[W-1];

endmodule

// File: rtl/scan_tester.sv
// Mux-scan test controller: shift stimulus in, one capture cycle, shift response out and compare.
module scan_tester
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned PI_W      = DEF_PI_W
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  output logic                 ready,
  input  logic [CHAIN_LEN-1:0] vec_in,
  input  logic [PI_W-1:0]      pi_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  output logic                 scan_m,
  output logic                 scan_i,
  input  logic                 scan_o,
  output logic [PI_W-1:0]      pi_out,
  output logic [CHAIN_LEN-1:0] resp,
  output logic                 done,
  output logic                 pass
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  st_t                 r_state;
  st_t                 w_next;
  logic [CW-1:0]       r_cnt;
  logic [PI_W-1:0]     r_pi;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-1:0] r_mask;

  logic                 r_ready;
  logic                 r_scan_m;
  logic [PI_W-1:0]      r_pi_out;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_done;
  logic                 r_pass;

  logic                 w_ready_nxt;
  logic                 w_scan_m_nxt;
  logic [PI_W-1:0]      w_pi_out_nxt;
  logic [CHAIN_LEN-1:0] w_resp_nxt;
  logic                 w_done_nxt;
  logic                 w_pass_nxt;

  logic                 w_accept;
  logic                 w_scan_i;
  logic [CHAIN_LEN-1:0] w_resp_sr;
  logic [CHAIN_LEN-1:0] w_stim_q_unused;
  logic                 w_resp_sout_unused;

  assign w_accept = (r_state == IDLE) && start;

  // Stimulus serialiser: loaded on accept, drains MSB first and back-fills zeros,
  // so scan_i is already 0 for the flush during SHIFT_OUT.
  scan_shreg #(.W(CHAIN_LEN)) u_stim (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_load     (w_accept),
    .i_load_val (vec_in),
    .i_shift    (r_state == SHIFT_IN),
    .i_sin      (1'b0),
    .o_q        (w_stim_q_unused),
    .o_sout     (w_scan_i)
  );

  // Response deserialiser: first sample taken ends up in the MSB.
  scan_shreg #(.W(CHAIN_LEN)) u_resp (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (r_state == SHIFT_OUT),
    .i_sin      (scan_o),
    .o_q        (w_resp_sr),
    .o_sout     (w_resp_sout_unused)
  );

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Shift counter, cleared on every state exit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == SHIFT_IN) || (r_state == SHIFT_OUT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start)        w_next = SHIFT_IN;
      SHIFT_IN:  if (r_cnt == LAST) w_next = CAPTURE;
      CAPTURE:                      w_next = SHIFT_OUT;
      SHIFT_OUT: if (r_cnt == LAST) w_next = DONE;
      DONE:                         w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  // Output decode: chain controls track the upcoming state; result flags follow DONE by one edge.
  always_comb begin
    w_ready_nxt  = (w_next == IDLE);
    w_scan_m_nxt = (w_next == SHIFT_IN) || (w_next == SHIFT_OUT);
    w_pi_out_nxt = r_pi_out;
    w_resp_nxt   = r_resp;
    w_done_nxt   = 1'b0;
    w_pass_nxt   = r_pass;
    if (w_next == CAPTURE) begin
      w_pi_out_nxt = r_pi;
    end
    if (r_state == DONE) begin
      w_done_nxt = 1'b1;
      w_resp_nxt = w_resp_sr;
      w_pass_nxt = (((w_resp_sr ^ r_exp) & r_mask) == '0);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ready  <= 1'b1;
      r_scan_m <= 1'b0;
      r_pi_out <= '0;
      r_resp   <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_ready  <= w_ready_nxt;
      r_scan_m <= w_scan_m_nxt;
      r_pi_out <= w_pi_out_nxt;
      r_resp   <= w_resp_nxt;
      r_done   <= w_done_nxt;
      r_pass   <= w_pass_nxt;
    end
  end

  // Vector operands latched on accept.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pi   <= '0;
      r_exp  <= '0;
      r_mask <= '0;
    end else if (w_accept) begin
      r_pi   <= pi_in;
      r_exp  <= exp_in;
      r_mask <= mask_in;
    end
  end

  assign ready  = r_ready;
  assign scan_m = r_scan_m;
  assign scan_i = w_scan_i;
  assign pi_out = r_pi_out;
  assign resp   = r_resp;
  assign done   = r_done;
  assign pass   = r_pass;

endmodule

// File: tb/tb_scan_tester.sv
// Scoreboard bench for scan_tester driving a 3-flop mux-scan chain model.
module tb_scan_tester;

  logic       clk;
  logic       n_reset;
  logic       start;
  logic       ready;
  logic [2:0] vec_in;
  logic [2:0] pi_in;
  logic [2:0] exp_in;
  logic [2:0] mask_in;
  logic       scan_m;
  logic       scan_i;
  logic       scan_o;
  logic [2:0] pi_out;
  logic [2:0] resp;
  logic       done;
  logic       pass;

  logic [2:0]  chain;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic [2:0]  vec;
    logic [2:0]  resp;
    logic        pass;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  logic prev_m;
  logic phase;

  scan_tester #(.CHAIN_LEN(3), .PI_W(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .ready   (ready),
    .vec_in  (vec_in),
    .pi_in   (pi_in),
    .exp_in  (exp_in),
    .mask_in (mask_in),
    .scan_m  (scan_m),
    .scan_i  (scan_i),
    .scan_o  (scan_o),
    .pi_out  (pi_out),
    .resp    (resp),
    .done    (done),
    .pass    (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux-scan chain model: flop 0 nearest scan-in, functional D = state ^ pi.
  initial chain = 3'b000;
  always @(posedge clk) begin
    if (scan_m) chain <= {chain[1:0], scan_i};
    else        chain <= chain ^ pi_out;
  end
  assign scan_o = chain[2];

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: chain checks on scan_m falling edges, result checks on done.
  always @(negedge clk) begin
    if (!n_reset) begin
      prev_m = 1'b0;
      phase  = 1'b0;
    end else begin
      if (prev_m && !scan_m) begin
        if (!phase) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL capture_unexpected: capture with empty scoreboard at cycle %0d", cyc);
          end else begin
            chk("pre_capture_chain", chain, sb[0].vec);
          end
        end else begin
          chk("flush_chain", chain, 0);
        end
        phase = !phase;
      end
      prev_m = scan_m;
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: done with empty scoreboard at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp", resp, e.resp);
          chk("pass", pass, e.pass);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_ready();
    int unsigned w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: ready still %0b after %0d cycles", ready, w);
    end
  endtask

  task automatic send(input logic [2:0] v, input logic [2:0] p, input logic [2:0] e,
                      input logic [2:0] m, input logic [2:0] r, input logic ps);
    wait_ready();
    vec_in = v; pi_in = p; exp_in = e; mask_in = m; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{v, r, ps, cyc + 8});
    start = 1'b0;
    vec_in = ~v; pi_in = ~p; exp_in = ~e; mask_in = ~m;
  endtask

  task automatic wait_drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0;
    n_tests = 0; n_fail = 0;
    n_reset = 1'b0; start = 1'b0;
    vec_in = '0; pi_in = '0; exp_in = '0; mask_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  ready,  1);
    chk("rst_scan_m", scan_m, 0);
    chk("rst_scan_i", scan_i, 0);
    chk("rst_pi_out", pi_out, 0);
    chk("rst_resp",   resp,   0);
    chk("rst_done",   done,   0);
    chk("rst_pass",   pass,   0);
    n_reset = 1'b1;

    // Basic shift-through, capture, shift-out.
    send(3'b101, 3'b000, 3'b101, 3'b111, 3'b101, 1'b1);
    wait_drain();
    // Capture with non-zero primary inputs: 110 ^ 011 = 101.
    send(3'b110, 3'b011, 3'b101, 3'b111, 3'b101, 1'b1);
    wait_drain();
    send(3'b110, 3'b011, 3'b100, 3'b111, 3'b101, 1'b0);
    wait_drain();
    // Masking: 000 ^ 111 = 111.
    send(3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 1'b1);
    wait_drain();
    send(3'b000, 3'b111, 3'b000, 3'b010, 3'b111, 1'b0);
    wait_drain();

    // Reset in the middle of SHIFT_IN discards the vector.
    send(3'b011, 3'b000, 3'b011, 3'b111, 3'b011, 1'b1);
    @(posedge clk); @(posedge clk); #2;
    n_reset = 1'b0;
    #1;
    chk("midrst_scan_m", scan_m, 0);
    chk("midrst_ready",  ready,  1);
    chk("midrst_done",   done,   0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done, 0);
    n_reset = 1'b1;
    // Clean vector after reset: 011 ^ 101 = 110.
    send(3'b011, 3'b101, 3'b110, 3'b111, 3'b110, 1'b1);
    wait_drain();

    // start held high: three vectors, one every 9 cycles.
    wait_ready();
    vec_in = 3'b110; pi_in = 3'b011; exp_in = 3'b101; mask_in = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    a0 = cyc;
    sb.push_back('{3'b110, 3'b101, 1'b1, a0 + 8});
    sb.push_back('{3'b110, 3'b101, 1'b1, a0 + 17});
    sb.push_back('{3'b110, 3'b101, 1'b1, a0 + 26});
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    chk("idle_after_b2b_ready", ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
